// File: rtl/deskew_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : deskew_job_sequencer
//  Purpose  : Register front end for the deskew core. It queues job
//             descriptors, launches them back-to-back, tracks completions
//             and errors, and raises one coalesced interrupt.
//  Revision : 1.0  initial release
// ============================================================================
module deskew_job_sequencer #(
    parameter int REG_ADDR_WIDTH = 8,
    parameter int DIM_WIDTH      = 9,
    parameter int ADDR_WIDTH     = 17,
    parameter int QUEUE_DEPTH    = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      write_reg,
    input  logic [REG_ADDR_WIDTH-1:0] reg_waddr,
    input  logic [31:0]               reg_wdata,
    input  logic                      read_reg,
    input  logic [REG_ADDR_WIDTH-1:0] reg_raddr,
    output logic [31:0]               reg_rdata,
    output logic [DIM_WIDTH-1:0]      img_dim,
    output logic [ADDR_WIDTH-1:0]     in_img_start_addr,
    output logic [ADDR_WIDTH-1:0]     out_img_start_addr,
    output logic                      start_dsqw,
    output logic                      soft_rst,
    input  logic                      dsqw_idle,
    input  logic                      dsqw_done,
    input  logic                      err_size,
    input  logic                      mem_acc_err,
    output logic                      dsqw_done_ack,
    output logic                      err_size_ack,
    output logic                      mem_acc_err_ack,
    output logic                      dsqw_irq
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [REG_ADDR_WIDTH-1:0] A_CTRL    = REG_ADDR_WIDTH'(32'h00);
    localparam logic [REG_ADDR_WIDTH-1:0] A_STG_DIM = REG_ADDR_WIDTH'(32'h04);
    localparam logic [REG_ADDR_WIDTH-1:0] A_STG_IN  = REG_ADDR_WIDTH'(32'h08);
    localparam logic [REG_ADDR_WIDTH-1:0] A_STG_OUT = REG_ADDR_WIDTH'(32'h0C);
    localparam logic [REG_ADDR_WIDTH-1:0] A_PUSH    = REG_ADDR_WIDTH'(32'h10);
    localparam logic [REG_ADDR_WIDTH-1:0] A_STATUS  = REG_ADDR_WIDTH'(32'h14);
    localparam logic [REG_ADDR_WIDTH-1:0] A_IRQ     = REG_ADDR_WIDTH'(32'h18);
    localparam logic [REG_ADDR_WIDTH-1:0] A_DONE    = REG_ADDR_WIDTH'(32'h1C);
    localparam logic [REG_ADDR_WIDTH-1:0] A_COAL    = REG_ADDR_WIDTH'(32'h20);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_ACK    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    err_q, err_d;
    logic                    run_en_q, irq_en_q;
    logic [DIM_WIDTH-1:0]    stg_dim_q;
    logic [ADDR_WIDTH-1:0]   stg_in_q, stg_out_q;
    logic [7:0]              coalesce_q;
    logic [DIM_WIDTH-1:0]    q_dim_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]   q_in_q  [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]   q_out_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q;
    logic [4:0]              irq_stat_q;
    logic [CNT_WIDTH-1:0]    done_cnt_q;
    logic [7:0]              coal_cnt_q;
    logic                    irq_q;
    logic [31:0]             rdata_q;
    logic [DIM_WIDTH-1:0]    img_dim_q;
    logic [ADDR_WIDTH-1:0]   in_addr_q, out_addr_q;
    logic                    start_q, soft_rst_q;
    logic                    done_ack_q, size_ack_q, mem_ack_q;
    logic                    done_ack_d, size_ack_d, mem_ack_d;

    logic        launch, pop, done_hit, size_set, mem_set;
    logic [31:0] rd_mux;
    logic [4:0]  set_mask, w1c_mask;

    // Register write decode
    logic wr_ctrl, wr_push, wr_irq, soft_rst_req;
    assign wr_ctrl      = write_reg && (reg_waddr == A_CTRL);
    assign wr_push      = write_reg && (reg_waddr == A_PUSH);
    assign wr_irq       = write_reg && (reg_waddr == A_IRQ);
    assign soft_rst_req = wr_ctrl && reg_wdata[2];

    // Queue status and push acceptance; a pop in the same cycle frees a slot
    logic q_empty, q_full, fsm_idle, push_bad, push_ok, push_ovf;
    assign q_empty  = (level_q == '0);
    assign q_full   = (level_q == LVL_W'(QUEUE_DEPTH));
    assign fsm_idle = (state_q == S_IDLE);
    assign push_bad = wr_push && (stg_dim_q == '0);
    assign push_ok  = wr_push && !push_bad && (!q_full || pop);
    assign push_ovf = wr_push && !push_bad && q_full && !pop;

    // Coalescing: a programmed value of 0 behaves as 1
    logic [8:0] coal_eff, coal_next;
    logic       done_evt_set;
    assign coal_eff     = (coalesce_q == 8'd0) ? 9'd1 : {1'b0, coalesce_q};
    assign coal_next    = {1'b0, coal_cnt_q} + 9'd1;
    assign done_evt_set = done_hit && ((coal_next >= coal_eff) || (level_q == LVL_W'(1)));

    assign set_mask = {push_bad, push_ovf, mem_set, size_set, done_evt_set};
    assign w1c_mask = wr_irq ? reg_wdata[4:0] : 5'd0;

    logic unused_wdata;
    assign unused_wdata = ^reg_wdata;

    // Software-visible control, staging and coalesce registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            stg_dim_q  <= '0;
            stg_in_q   <= '0;
            stg_out_q  <= '0;
            coalesce_q <= '0;
        end else if (write_reg) begin
            if (reg_waddr == A_CTRL) begin
                run_en_q <= reg_wdata[0];
                irq_en_q <= reg_wdata[1];
            end
            if (reg_waddr == A_STG_DIM) stg_dim_q  <= reg_wdata[DIM_WIDTH-1:0];
            if (reg_waddr == A_STG_IN)  stg_in_q   <= reg_wdata[ADDR_WIDTH-1:0];
            if (reg_waddr == A_STG_OUT) stg_out_q  <= reg_wdata[ADDR_WIDTH-1:0];
            if (reg_waddr == A_COAL)    coalesce_q <= reg_wdata[7:0];
        end
    end

    // Descriptor FIFO; soft reset only rewinds the pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_dim_q[i] <= '0;
                q_in_q[i]  <= '0;
                q_out_q[i] <= '0;
            end
        end else if (soft_rst_req) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                q_dim_q[wr_ptr_q] <= stg_dim_q;
                q_in_q[wr_ptr_q]  <= stg_in_q;
                q_out_q[wr_ptr_q] <= stg_out_q;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop);
        end
    end

    // Job FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Job FSM next state, acks and event strobes; soft reset overrides all
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        launch     = 1'b0;
        pop        = 1'b0;
        done_hit   = 1'b0;
        size_set   = 1'b0;
        mem_set    = 1'b0;
        done_ack_d = 1'b0;
        size_ack_d = 1'b0;
        mem_ack_d  = 1'b0;
        case (state_q)
            S_IDLE: if (run_en_q && !q_empty && dsqw_idle) state_d = S_LAUNCH;
            S_LAUNCH: begin
                launch  = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: if (dsqw_done || err_size || mem_acc_err) begin
                state_d    = S_ACK;
                err_d      = err_size || mem_acc_err;
                done_ack_d = dsqw_done;
                size_ack_d = err_size;
                mem_ack_d  = mem_acc_err;
                size_set   = err_size;
                mem_set    = mem_acc_err;
                done_hit   = dsqw_done && !err_size && !mem_acc_err;
            end
            S_ACK: begin
                pop     = 1'b1;
                state_d = err_q ? S_HALT : S_IDLE;
            end
            S_HALT: if (!irq_stat_q[1] && !irq_stat_q[2]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (soft_rst_req) begin
            state_d    = S_IDLE;
            err_d      = 1'b0;
            launch     = 1'b0;
            pop        = 1'b0;
            done_hit   = 1'b0;
            size_set   = 1'b0;
            mem_set    = 1'b0;
            done_ack_d = 1'b0;
            size_ack_d = 1'b0;
            mem_ack_d  = 1'b0;
        end
    end

    // Core-facing outputs: descriptor held from one launch to the next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_dim_q  <= '0;
            in_addr_q  <= '0;
            out_addr_q <= '0;
            start_q    <= 1'b0;
            soft_rst_q <= 1'b0;
            done_ack_q <= 1'b0;
            size_ack_q <= 1'b0;
            mem_ack_q  <= 1'b0;
        end else begin
            if (launch) begin
                img_dim_q  <= q_dim_q[rd_ptr_q];
                in_addr_q  <= q_in_q[rd_ptr_q];
                out_addr_q <= q_out_q[rd_ptr_q];
            end
            start_q    <= launch;
            soft_rst_q <= soft_rst_req;
            done_ack_q <= done_ack_d;
            size_ack_q <= size_ack_d;
            mem_ack_q  <= mem_ack_d;
        end
    end

    // Interrupt status (set beats clear), completion counters, irq line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_stat_q <= '0;
            done_cnt_q <= '0;
            coal_cnt_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_q <= irq_en_q && (|irq_stat_q);
            if (soft_rst_req) begin
                irq_stat_q <= '0;
                done_cnt_q <= '0;
                coal_cnt_q <= '0;
            end else begin
                irq_stat_q <= (irq_stat_q & ~w1c_mask) | set_mask;
                if (done_hit) begin
                    done_cnt_q <= done_cnt_q + CNT_WIDTH'(1);
                    coal_cnt_q <= done_evt_set ? 8'd0 : coal_next[7:0];
                end
            end
        end
    end

    // Read data selection
    always_comb begin
        rd_mux = '0;
        case (reg_raddr)
            A_CTRL:    rd_mux = {30'd0, irq_en_q, run_en_q};
            A_STG_DIM: rd_mux = 32'(stg_dim_q);
            A_STG_IN:  rd_mux = 32'(stg_in_q);
            A_STG_OUT: rd_mux = 32'(stg_out_q);
            A_STATUS:  rd_mux = {8'd0, 5'd0, state_q, 8'(level_q), 5'd0, q_full, q_empty, fsm_idle};
            A_IRQ:     rd_mux = {27'd0, irq_stat_q};
            A_DONE:    rd_mux = 32'(done_cnt_q);
            A_COAL:    rd_mux = {24'd0, coalesce_q};
            default:   rd_mux = '0;
        endcase
    end

    // Read data register, held between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rdata_q <= '0;
        else if (read_reg) rdata_q <= rd_mux;
    end

    assign reg_rdata          = rdata_q;
    assign img_dim            = img_dim_q;
    assign in_img_start_addr  = in_addr_q;
    assign out_img_start_addr = out_addr_q;
    assign start_dsqw         = start_q;
    assign soft_rst           = soft_rst_q;
    assign dsqw_done_ack      = done_ack_q;
    assign err_size_ack       = size_ack_q;
    assign mem_acc_err_ack    = mem_ack_q;
    assign dsqw_irq           = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_deskew_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_deskew_job_sequencer
//  Purpose  : Directed self-checking bench with a small deskew core model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_deskew_job_sequencer;

    localparam logic [7:0] A_CTRL = 8'h00, A_STG_DIM = 8'h04, A_STG_IN = 8'h08,
                           A_STG_OUT = 8'h0C, A_PUSH = 8'h10, A_STATUS = 8'h14,
                           A_IRQ = 8'h18, A_DONE = 8'h1C, A_COAL = 8'h20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write_reg, read_reg;
    logic [7:0]  reg_waddr, reg_raddr;
    logic [31:0] reg_wdata, reg_rdata;
    logic [8:0]  img_dim;
    logic [16:0] in_img_start_addr, out_img_start_addr;
    logic        start_dsqw, soft_rst, dsqw_idle, dsqw_done, err_size, mem_acc_err;
    logic        dsqw_done_ack, err_size_ack, mem_acc_err_ack, dsqw_irq;

    int n_tests = 0, n_fail = 0;
    int n_starts, n_dack = 0, n_mack = 0, n_soft = 0;
    int mem_err_job = 0;
    bit core_run = 1'b1;
    logic [2:0]  core_dly;
    logic        core_busy;
    logic [8:0]  log_dim [0:63];
    logic [16:0] log_in  [0:63];
    logic [16:0] log_out [0:63];

    always #5 clk = ~clk;

    deskew_job_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .write_reg(write_reg), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .read_reg(read_reg), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .img_dim(img_dim), .in_img_start_addr(in_img_start_addr),
        .out_img_start_addr(out_img_start_addr),
        .start_dsqw(start_dsqw), .soft_rst(soft_rst),
        .dsqw_idle(dsqw_idle), .dsqw_done(dsqw_done),
        .err_size(err_size), .mem_acc_err(mem_acc_err),
        .dsqw_done_ack(dsqw_done_ack), .err_size_ack(err_size_ack),
        .mem_acc_err_ack(mem_acc_err_ack), .dsqw_irq(dsqw_irq)
    );

    // Core model: logs each launch, finishes after a few cycles, holds done/err until acked
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || soft_rst) begin
            core_busy <= 1'b0; core_dly <= '0; dsqw_done <= 1'b0;
            mem_acc_err <= 1'b0; err_size <= 1'b0; dsqw_idle <= 1'b1;
            if (!rst_n) n_starts <= 0;
        end else begin
            if (start_dsqw) begin
                core_busy <= 1'b1; core_dly <= 3'd3; dsqw_idle <= 1'b0;
                if (n_starts < 64) begin
                    log_dim[n_starts] <= img_dim;
                    log_in[n_starts]  <= in_img_start_addr;
                    log_out[n_starts] <= out_img_start_addr;
                end
                n_starts <= n_starts + 1;
            end else if (core_busy && core_run) begin
                if (core_dly == 3'd0) begin
                    core_busy <= 1'b0;
                    if (mem_err_job == n_starts) mem_acc_err <= 1'b1;
                    else dsqw_done <= 1'b1;
                end else core_dly <= core_dly - 3'd1;
            end
            if (dsqw_done_ack)   dsqw_done   <= 1'b0;
            if (mem_acc_err_ack) mem_acc_err <= 1'b0;
            if (err_size_ack)    err_size    <= 1'b0;
            if (dsqw_done_ack || mem_acc_err_ack || err_size_ack) dsqw_idle <= 1'b1;
        end
    end

    // Pulse-cycle counters for acks and soft reset
    always @(posedge clk) begin
        if (dsqw_done_ack)   n_dack++;
        if (mem_acc_err_ack) n_mack++;
        if (soft_rst)        n_soft++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk); write_reg = 1'b1; reg_waddr = a; reg_wdata = d;
        @(negedge clk); write_reg = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk); read_reg = 1'b1; reg_raddr = a;
        @(negedge clk); read_reg = 1'b0; d = reg_rdata;
    endtask

    task automatic wait_start(input int budget, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (start_dsqw !== 1'b1 && cyc < budget);
        if (start_dsqw !== 1'b1) check_val("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_status(input logic [31:0] mask, input logic [31:0] val,
                               input int budget, input string tag);
        logic [31:0] s;
        int n = 0;
        do begin rd(A_STATUS, s); n++; end while (((s & mask) !== val) && n < budget);
        check_val(tag, s & mask, val);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int c, base, a0, s0, n;
        write_reg = 0; read_reg = 0; reg_waddr = 0; reg_raddr = 0; reg_wdata = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_val("rst_rdata", reg_rdata, 32'd0);
        check_val("rst_pulses", {26'd0, start_dsqw, soft_rst, dsqw_irq, dsqw_done_ack,
                                 err_size_ack, mem_acc_err_ack}, 32'd0);
        check_val("rst_dim", 32'(img_dim), 32'd0);
        rd(A_STATUS, d); check_val("rst_status", d, 32'h3);
        rd(A_DONE, d);   check_val("rst_donecnt", d, 32'd0);

        // Single job, launch latency and completion interrupt
        wr(A_CTRL, 32'h2); wr(A_STG_DIM, 256); wr(A_STG_IN, 32'h100); wr(A_STG_OUT, 32'h8100);
        wr(A_PUSH, 0);
        rd(A_STATUS, d); check_val("t1_status_queued", d, 32'h101);
        wr(A_CTRL, 32'h3);
        wait_start(20, c);
        check_val("t1_start_latency", c, 2);
        check_val("t1_dim", 32'(img_dim), 32'd256);
        check_val("t1_in", 32'(in_img_start_addr), 32'h100);
        check_val("t1_out", 32'(out_img_start_addr), 32'h8100);
        @(negedge clk); check_val("t1_start_width", 32'(start_dsqw), 32'd0);
        wait_status(32'h3, 32'h3, 200, "t1_drain");
        rd(A_DONE, d); check_val("t1_donecnt", d, 32'd1);
        rd(A_IRQ, d);  check_val("t1_irqstat", d, 32'h1);
        check_val("t1_irq_line", 32'(dsqw_irq), 32'd1);
        check_val("t1_done_acks", n_dack, 1);
        wr(A_IRQ, 32'h1F); repeat (2) @(negedge clk);
        check_val("t1_irq_cleared", 32'(dsqw_irq), 32'd0);

        // Fill the queue, overflow, FIFO order
        wr(A_CTRL, 32'h6);
        base = n_starts;
        for (int i = 0; i < 5; i++) begin
            wr(A_STG_DIM, 32'(10 + i)); wr(A_STG_IN, 32'(16 + i)); wr(A_STG_OUT, 32'(32 + i));
            wr(A_PUSH, 0);
        end
        rd(A_STATUS, d); check_val("t2_status_full", d, 32'h405);
        rd(A_IRQ, d);    check_val("t2_overflow", d, 32'h8);
        wr(A_IRQ, 32'h8);
        wr(A_CTRL, 32'h3);
        wait_status(32'h3, 32'h3, 300, "t2_drain");
        check_val("t2_start_count", n_starts - base, 4);
        for (int i = 0; i < 4; i++) begin
            check_val("t2_job_dim", 32'(log_dim[base + i]), 32'(10 + i));
            check_val("t2_job_in",  32'(log_in[base + i]),  32'(16 + i));
            check_val("t2_job_out", 32'(log_out[base + i]), 32'(32 + i));
        end
        rd(A_DONE, d); check_val("t2_donecnt", d, 32'd4);
        check_val("t2_soft_pulses", n_soft, 1);

        // Coalescing by two, then on queue empty
        wr(A_CTRL, 32'h6); wr(A_COAL, 2);
        for (int i = 0; i < 3; i++) begin wr(A_STG_DIM, 32'(30 + i)); wr(A_PUSH, 0); end
        wr(A_CTRL, 32'h3);
        wait_start(100, c);
        wait_start(100, c); core_run = 1'b0;
        rd(A_IRQ, d); check_val("t3_no_evt_job1", d, 32'h0);
        core_run = 1'b1;
        wait_start(100, c); core_run = 1'b0;
        rd(A_IRQ, d); check_val("t3_evt_job2", d, 32'h1);
        wr(A_IRQ, 32'h1);
        rd(A_IRQ, d); check_val("t3_w1c", d, 32'h0);
        core_run = 1'b1;
        wait_status(32'h3, 32'h3, 200, "t3_drain");
        rd(A_IRQ, d);  check_val("t3_evt_empty", d, 32'h1);
        rd(A_DONE, d); check_val("t3_donecnt", d, 32'd3);

        // Memory error on job 2 halts with job 3 queued
        wr(A_CTRL, 32'h6);
        base = n_starts; mem_err_job = base + 2;
        for (int i = 0; i < 3; i++) begin wr(A_STG_DIM, 32'(40 + i)); wr(A_PUSH, 0); end
        wr(A_CTRL, 32'h3);
        wait_status(32'h00FF0000, 32'h00040000, 200, "t4_halt");
        rd(A_STATUS, d); check_val("t4_status", d, 32'h00040100);
        rd(A_IRQ, d);    check_val("t4_irqstat", d, 32'h4);
        check_val("t4_mem_acks", n_mack, 1);
        rd(A_DONE, d);   check_val("t4_donecnt", d, 32'd1);
        repeat (10) @(negedge clk);
        check_val("t4_held", n_starts - base, 2);
        mem_err_job = 0;
        wr(A_IRQ, 32'h4);
        wait_status(32'h3, 32'h3, 200, "t4_drain");
        check_val("t4_resumed", n_starts - base, 3);
        check_val("t4_job3_dim", 32'(log_dim[base + 2]), 32'd42);
        rd(A_DONE, d); check_val("t4_donecnt_end", d, 32'd2);
        rd(A_IRQ, d);  check_val("t4_irq_end", d, 32'h1);

        // Soft reset while a job runs
        wr(A_CTRL, 32'h6);
        base = n_starts;
        wr(A_STG_DIM, 77); wr(A_STG_IN, 32'h77); wr(A_STG_OUT, 32'h99);
        wr(A_PUSH, 0); wr(A_PUSH, 0);
        wr(A_CTRL, 32'h3);
        wait_start(100, c); core_run = 1'b0;
        repeat (3) @(negedge clk);
        a0 = n_dack; s0 = n_soft;
        wr(A_CTRL, 32'h7);
        @(negedge clk);
        check_val("t5_soft_pulse", n_soft - s0, 1);
        check_val("t5_soft_width", 32'(soft_rst), 32'd0);
        rd(A_STATUS, d);  check_val("t5_status", d, 32'h3);
        check_val("t5_no_ack", n_dack - a0, 0);
        rd(A_DONE, d);    check_val("t5_donecnt", d, 32'd0);
        rd(A_STG_DIM, d); check_val("t5_stg_dim", d, 32'd77);
        rd(A_STG_IN, d);  check_val("t5_stg_in", d, 32'h77);
        rd(A_STG_OUT, d); check_val("t5_stg_out", d, 32'h99);
        rd(A_CTRL, d);    check_val("t5_ctrl", d, 32'h3);
        core_run = 1'b1;
        repeat (20) @(negedge clk);
        check_val("t5_no_relaunch", n_starts - base, 1);

        // Bad descriptor, then push and pop together at full
        wr(A_CTRL, 32'h6);
        wr(A_STG_DIM, 0); wr(A_PUSH, 0);
        rd(A_IRQ, d);    check_val("t6_bad_desc", d, 32'h10);
        rd(A_STATUS, d); check_val("t6_bad_level", d, 32'h3);
        wr(A_IRQ, 32'h10);
        base = n_starts;
        for (int i = 0; i < 4; i++) begin wr(A_STG_DIM, 32'(21 + i)); wr(A_PUSH, 0); end
        wr(A_STG_DIM, 25);
        wr(A_CTRL, 32'h3);
        n = 0;
        while (dsqw_done_ack !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check_val("t6_ack_seen", 32'(dsqw_done_ack), 32'd1);
        write_reg = 1'b1; reg_waddr = A_PUSH;
        @(negedge clk); write_reg = 1'b0; core_run = 1'b0;
        rd(A_STATUS, d); check_val("t6_pushpop_level", d & 32'hFF06, 32'h0404);
        rd(A_IRQ, d);    check_val("t6_no_overflow", d, 32'h0);
        core_run = 1'b1;
        wait_status(32'h3, 32'h3, 300, "t6_drain");
        check_val("t6_start_count", n_starts - base, 5);
        for (int i = 0; i < 5; i++)
            check_val("t6_job_dim", 32'(log_dim[base + i]), 32'(21 + i));
        rd(A_DONE, d); check_val("t6_donecnt", d, 32'd5);
        rd(A_IRQ, d);  check_val("t6_irq_end", d, 32'h1);

        // Asynchronous reset in the middle of a job
        wr(A_STG_DIM, 50); wr(A_PUSH, 0);
        wait_start(100, c); core_run = 1'b0;
        repeat (2) @(negedge clk);
        check_val("t7_pre_dim", 32'(img_dim), 32'd50);
        #2 rst_n = 1'b0;
        #1;
        check_val("t7_async_dim", 32'(img_dim), 32'd0);
        check_val("t7_async_irq", 32'(dsqw_irq), 32'd0);
        @(negedge clk); rst_n = 1'b1; core_run = 1'b1;
        rd(A_STATUS, d);  check_val("t7_status", d, 32'h3);
        rd(A_CTRL, d);    check_val("t7_ctrl", d, 32'h0);
        rd(A_STG_DIM, d); check_val("t7_stg_dim", d, 32'd0);
        rd(A_DONE, d);    check_val("t7_donecnt", d, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
